// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//
// Shares one single-port memory between the instruction-fetch (IF) port and
// the load/store unit (LSU) port. Only one transaction is outstanding at a
// time. Simultaneous requests are resolved round-robin. All memory-side
// outputs come from registers. Grants and responses are combinational.
//
// Ports
//   clk_i, rst_i          clock, synchronous active-high reset
//   if_req_i/if_addr_i    IF read request (held until if_gnt_o)
//   if_gnt_o              IF request accepted (one-cycle pulse)
//   if_rvalid_o/rdata_o   IF response (rdata is 0 when rvalid is low)
//   lsu_req_i/we/be/addr/wdata  LSU request and attributes
//   lsu_gnt_o             LSU request accepted (one-cycle pulse)
//   lsu_rvalid_o/rdata_o  LSU response (also pulses for writes)
//   mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o
//                         registered memory request, held until mem_gnt_i
//   mem_gnt_i             memory accepts the request this cycle
//   mem_rvalid_i/rdata_i  memory response
// ---------------------------------------------------------------------------
module mem_arbiter #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,

    input  logic            if_req_i,
    input  logic [XLEN-1:0] if_addr_i,
    output logic            if_gnt_o,
    output logic            if_rvalid_o,
    output logic [XLEN-1:0] if_rdata_o,

    input  logic            lsu_req_i,
    input  logic            lsu_we_i,
    input  logic [3:0]      lsu_be_i,
    input  logic [XLEN-1:0] lsu_addr_i,
    input  logic [XLEN-1:0] lsu_wdata_i,
    output logic            lsu_gnt_o,
    output logic            lsu_rvalid_o,
    output logic [XLEN-1:0] lsu_rdata_o,

    output logic            mem_req_o,
    output logic            mem_we_o,
    output logic [3:0]      mem_be_o,
    output logic [XLEN-1:0] mem_addr_o,
    output logic [XLEN-1:0] mem_wdata_o,
    input  logic            mem_gnt_i,
    input  logic            mem_rvalid_i,
    input  logic [XLEN-1:0] mem_rdata_i
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RSP  = 2'd2
    } state_e;

    // Requester identity, used for both the owner and the last-served pointer.
    localparam logic OWN_IF  = 1'b0;
    localparam logic OWN_LSU = 1'b1;

    state_e          state_q, state_d;
    logic            owner_q, owner_d;
    logic            last_q,  last_d;
    logic            mem_req_q,   mem_req_d;
    logic            mem_we_q,    mem_we_d;
    logic [3:0]      mem_be_q,    mem_be_d;
    logic [XLEN-1:0] mem_addr_q,  mem_addr_d;
    logic [XLEN-1:0] mem_wdata_q, mem_wdata_d;

    logic            pick_lsu;
    logic            if_gnt, lsu_gnt;
    logic            if_rvalid, lsu_rvalid;
    logic [XLEN-1:0] if_rdata, lsu_rdata;

    // LSU wins when it is alone, or on a tie when IF was served last.
    assign pick_lsu = lsu_req_i && (!if_req_i || (last_q == OWN_IF));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            owner_q     <= OWN_IF;
            last_q      <= OWN_IF;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= 4'h0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_be_q    <= mem_be_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_d      = last_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_be_d    = mem_be_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_gnt      = 1'b0;
        lsu_gnt     = 1'b0;
        if_rvalid   = 1'b0;
        lsu_rvalid  = 1'b0;
        if_rdata    = '0;
        lsu_rdata   = '0;

        unique case (state_q)
            ST_IDLE: begin
                // Grants are suppressed while reset is asserted so that a
                // request held across reset is never accepted and then lost.
                if (!rst_i && (if_req_i || lsu_req_i)) begin
                    state_d   = ST_REQ;
                    mem_req_d = 1'b1;
                    owner_d   = pick_lsu;
                    last_d    = pick_lsu;
                    if (pick_lsu) begin
                        lsu_gnt     = 1'b1;
                        mem_we_d    = lsu_we_i;
                        mem_be_d    = lsu_be_i;
                        mem_addr_d  = lsu_addr_i;
                        mem_wdata_d = lsu_wdata_i;
                    end else begin
                        // Fetches are always full-word reads.
                        if_gnt      = 1'b1;
                        mem_we_d    = 1'b0;
                        mem_be_d    = 4'hF;
                        mem_addr_d  = if_addr_i;
                        mem_wdata_d = '0;
                    end
                end
            end

            ST_REQ: begin
                if (mem_gnt_i) begin
                    state_d   = ST_RSP;
                    mem_req_d = 1'b0;
                end
            end

            ST_RSP: begin
                // Read data is forwarded unchanged for writes as well; the
                // LSU simply ignores it.
                if (!rst_i && mem_rvalid_i) begin
                    state_d = ST_IDLE;
                    if (owner_q == OWN_LSU) begin
                        lsu_rvalid = 1'b1;
                        lsu_rdata  = mem_rdata_i;
                    end else begin
                        if_rvalid  = 1'b1;
                        if_rdata   = mem_rdata_i;
                    end
                end
            end

            default: begin
                state_d   = ST_IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    assign if_gnt_o     = if_gnt;
    assign lsu_gnt_o    = lsu_gnt;
    assign if_rvalid_o  = if_rvalid;
    assign lsu_rvalid_o = lsu_rvalid;
    assign if_rdata_o   = if_rdata;
    assign lsu_rdata_o  = lsu_rdata;

    assign mem_req_o    = mem_req_q;
    assign mem_we_o     = mem_we_q;
    assign mem_be_o     = mem_be_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_wdata_o  = mem_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
//
// Directed bench for mem_arbiter. The stimulus process drives requests and
// pushes hand-computed expectations (grant owner/cycle, response owner/data/
// cycle, memory-side attributes per cycle) into queues. A negedge monitor
// pops and compares whenever the DUT presents a grant or response, and
// checks the attribute queue on the cycles it names. A small memory model
// answers mem_req_o with a configurable grant stall and response delay.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst_i = 1'b1;
    logic            if_req_i = 1'b0;
    logic [XLEN-1:0] if_addr_i = '0;
    logic            if_gnt_o, if_rvalid_o;
    logic [XLEN-1:0] if_rdata_o;
    logic            lsu_req_i = 1'b0;
    logic            lsu_we_i = 1'b0;
    logic [3:0]      lsu_be_i = 4'h0;
    logic [XLEN-1:0] lsu_addr_i = '0;
    logic [XLEN-1:0] lsu_wdata_i = '0;
    logic            lsu_gnt_o, lsu_rvalid_o;
    logic [XLEN-1:0] lsu_rdata_o;
    logic            mem_req_o, mem_we_o;
    logic [3:0]      mem_be_o;
    logic [XLEN-1:0] mem_addr_o, mem_wdata_o;
    logic            mem_gnt_i, mem_rvalid_i;
    logic [XLEN-1:0] mem_rdata_i;

    // Memory-side inputs: automatic model OR manual (spurious) injection.
    logic            auto_gnt = 1'b0, auto_rvalid = 1'b0;
    logic [XLEN-1:0] auto_rdata = '0;
    logic            man_gnt = 1'b0, man_rvalid = 1'b0;
    logic [XLEN-1:0] man_rdata = '0;
    assign mem_gnt_i    = auto_gnt | man_gnt;
    assign mem_rvalid_i = auto_rvalid | man_rvalid;
    assign mem_rdata_i  = auto_rdata | man_rdata;

    int stall_cfg = 0;
    int rsp_delay = 0;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    mem_arbiter #(.XLEN(XLEN)) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .if_req_i     (if_req_i),
        .if_addr_i    (if_addr_i),
        .if_gnt_o     (if_gnt_o),
        .if_rvalid_o  (if_rvalid_o),
        .if_rdata_o   (if_rdata_o),
        .lsu_req_i    (lsu_req_i),
        .lsu_we_i     (lsu_we_i),
        .lsu_be_i     (lsu_be_i),
        .lsu_addr_i   (lsu_addr_i),
        .lsu_wdata_i  (lsu_wdata_i),
        .lsu_gnt_o    (lsu_gnt_o),
        .lsu_rvalid_o (lsu_rvalid_o),
        .lsu_rdata_o  (lsu_rdata_o),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .mem_be_o     (mem_be_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_gnt_i    (mem_gnt_i),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i)
    );

    // ------------------------------------------------------------------
    // Memory model
    // ------------------------------------------------------------------
    logic [XLEN-1:0] tb_mem [0:255];

    initial begin
        int         scnt;
        int         wait_n;
        bit         pend;
        logic [31:0] pdata;
        logic [31:0] w;
        logic [7:0]  idx;
        scnt = 0; wait_n = 0; pend = 1'b0; pdata = '0;
        for (int i = 0; i < 256; i++) tb_mem[i] = '0;
        tb_mem[4]  = 32'h0050_0093;   // 0x010
        tb_mem[8]  = 32'hCAFE_F00D;   // 0x020
        tb_mem[64] = 32'h1122_3344;   // 0x100
        forever begin
            @(posedge clk); #2;
            auto_gnt = 1'b0; auto_rvalid = 1'b0; auto_rdata = '0;
            if (rst_i) begin
                pend = 1'b0; scnt = 0;
            end else if (pend) begin
                if (wait_n == 0) begin
                    auto_rvalid = 1'b1;
                    auto_rdata  = pdata;
                    pend        = 1'b0;
                end else begin
                    wait_n--;
                end
            end else if (mem_req_o) begin
                if (scnt < stall_cfg) begin
                    scnt++;
                end else begin
                    auto_gnt = 1'b1;
                    scnt     = 0;
                    pend     = 1'b1;
                    wait_n   = rsp_delay;
                    idx      = mem_addr_o[9:2];
                    if (mem_we_o) begin
                        w = tb_mem[idx];
                        for (int b = 0; b < 4; b++)
                            if (mem_be_o[b]) w[8*b +: 8] = mem_wdata_o[8*b +: 8];
                        tb_mem[idx] = w;
                    end
                    pdata = tb_mem[idx];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Scoreboard queues
    // ------------------------------------------------------------------
    typedef struct {
        logic        lsu;
        logic [31:0] data;
        int          cyc;
    } ev_t;

    typedef struct {
        int          cyc;
        logic        req;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        ca;   // compare we/be/addr
        logic        cw;   // compare wdata
    } attr_t;

    ev_t   gq[$];
    ev_t   rq[$];
    attr_t aq[$];

    int checks   = 0;
    int failures = 0;
    bit done     = 1'b0;
    bit mon_done = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        ev_t   e;
        attr_t a;
        if (if_gnt_o || lsu_gnt_o) begin
            chk("gnt_exclusive", 64'(if_gnt_o & lsu_gnt_o), 64'd0);
            if (gq.size() == 0) begin
                chk("gnt_unexpected", 64'd1, 64'd0);
            end else begin
                e = gq.pop_front();
                chk("gnt_owner_lsu", 64'(lsu_gnt_o), 64'(e.lsu));
                chk("gnt_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
        if (if_rvalid_o || lsu_rvalid_o) begin
            chk("rvalid_exclusive", 64'(if_rvalid_o & lsu_rvalid_o), 64'd0);
            if (rq.size() == 0) begin
                chk("rvalid_unexpected", 64'd1, 64'd0);
            end else begin
                e = rq.pop_front();
                chk("rvalid_owner_lsu", 64'(lsu_rvalid_o), 64'(e.lsu));
                chk("rdata", 64'(lsu_rvalid_o ? lsu_rdata_o : if_rdata_o), 64'(e.data));
                chk("rvalid_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
        if (!if_rvalid_o)  chk("if_rdata_idle",  64'(if_rdata_o),  64'd0);
        if (!lsu_rvalid_o) chk("lsu_rdata_idle", 64'(lsu_rdata_o), 64'd0);

        while (aq.size() > 0 && aq[0].cyc < cyc) begin
            a = aq.pop_front();
            chk("attr_missed_cycle", 64'(cyc), 64'(a.cyc));
        end
        if (aq.size() > 0 && aq[0].cyc == cyc) begin
            a = aq.pop_front();
            chk("mem_req", 64'(mem_req_o), 64'(a.req));
            if (a.ca) begin
                chk("mem_we",   64'(mem_we_o),   64'(a.we));
                chk("mem_be",   64'(mem_be_o),   64'(a.be));
                chk("mem_addr", 64'(mem_addr_o), 64'(a.addr));
            end
            if (a.cw) chk("mem_wdata", 64'(mem_wdata_o), 64'(a.wdata));
        end

        if (done && !mon_done) begin
            chk("gnt_left_over",    64'(gq.size()), 64'd0);
            chk("rvalid_left_over", 64'(rq.size()), 64'd0);
            chk("attr_left_over",   64'(aq.size()), 64'd0);
            mon_done = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic push_g(input logic l, input int c);
        ev_t e;
        e.lsu = l; e.data = '0; e.cyc = c;
        gq.push_back(e);
    endtask

    task automatic push_r(input logic l, input logic [31:0] d, input int c);
        ev_t e;
        e.lsu = l; e.data = d; e.cyc = c;
        rq.push_back(e);
    endtask

    task automatic push_a(input int c, input logic req, input logic we, input logic [3:0] be,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic ca, input logic cw);
        attr_t a;
        a.cyc = c; a.req = req; a.we = we; a.be = be;
        a.addr = addr; a.wdata = wdata; a.ca = ca; a.cw = cw;
        aq.push_back(a);
    endtask

    task automatic drive_if(input logic [31:0] a);
        if_req_i = 1'b1; if_addr_i = a;
    endtask

    task automatic drop_if();
        if_req_i = 1'b0; if_addr_i = '0;
    endtask

    task automatic drive_lsu(input logic we, input logic [3:0] be, input logic [31:0] a,
                             input logic [31:0] wd);
        lsu_req_i = 1'b1; lsu_we_i = we; lsu_be_i = be; lsu_addr_i = a; lsu_wdata_i = wd;
    endtask

    task automatic drop_lsu();
        lsu_req_i = 1'b0; lsu_we_i = 1'b0; lsu_be_i = 4'h0; lsu_addr_i = '0; lsu_wdata_i = '0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 60; i++) begin
            if (gq.size() == 0 && rq.size() == 0 && aq.size() == 0) break;
            tick();
        end
        tick();
        tick();
    endtask

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin
        int c;

        // Reset values
        rst_i = 1'b1;
        tick();
        tick();
        push_a(cyc, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b1);
        tick();
        rst_i = 1'b0;
        tick();

        // IF read only
        c = cyc;
        drive_if(32'h0000_0010);
        push_g(1'b0, c);
        push_a(c + 1, 1'b1, 1'b0, 4'hF, 32'h0000_0010, 32'h0, 1'b1, 1'b0);
        push_r(1'b0, 32'h0050_0093, c + 2);
        tick();
        drop_if();
        wait_idle();

        // LSU partial write: 0x11223344 with bytes 1:0 <- BEEF
        c = cyc;
        drive_lsu(1'b1, 4'b0011, 32'h0000_0100, 32'hDEAD_BEEF);
        push_g(1'b1, c);
        push_a(c + 1, 1'b1, 1'b1, 4'b0011, 32'h0000_0100, 32'hDEAD_BEEF, 1'b1, 1'b1);
        push_r(1'b1, 32'h1122_BEEF, c + 2);
        tick();
        drop_lsu();
        wait_idle();

        // LSU read back of the merged word
        c = cyc;
        drive_lsu(1'b0, 4'hF, 32'h0000_0100, 32'h0);
        push_g(1'b1, c);
        push_a(c + 1, 1'b1, 1'b0, 4'hF, 32'h0000_0100, 32'h0, 1'b1, 1'b1);
        push_r(1'b1, 32'h1122_BEEF, c + 2);
        tick();
        drop_lsu();
        wait_idle();

        // Simultaneous held requests right after reset: LSU, IF, LSU, IF
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        c = cyc;
        drive_if(32'h0000_0010);
        drive_lsu(1'b0, 4'hF, 32'h0000_0100, 32'h0);
        push_g(1'b1, c);
        push_g(1'b0, c + 3);
        push_g(1'b1, c + 6);
        push_g(1'b0, c + 9);
        push_r(1'b1, 32'h1122_BEEF, c + 2);
        push_r(1'b0, 32'h0050_0093, c + 5);
        push_r(1'b1, 32'h1122_BEEF, c + 8);
        push_r(1'b0, 32'h0050_0093, c + 11);
        for (int i = 0; i < 10; i++) tick();
        drop_if();
        drop_lsu();
        wait_idle();

        // Memory stall of 4 cycles, LSU waiting behind it
        c = cyc;
        stall_cfg = 4;
        drive_if(32'h0000_0020);
        push_g(1'b0, c);
        for (int k = 1; k <= 4; k++)
            push_a(c + k, 1'b1, 1'b0, 4'hF, 32'h0000_0020, 32'h0, 1'b1, 1'b0);
        push_r(1'b0, 32'hCAFE_F00D, c + 6);
        tick();
        drop_if();
        drive_lsu(1'b0, 4'hF, 32'h0000_0100, 32'h0);
        push_g(1'b1, c + 7);
        push_r(1'b1, 32'h1122_BEEF, c + 9);
        for (int i = 0; i < 5; i++) tick();
        stall_cfg = 0;
        tick();
        tick();
        drop_lsu();
        wait_idle();

        // Reset while waiting for an LSU response, stray rvalid afterwards
        c = cyc;
        rsp_delay = 3;
        drive_lsu(1'b0, 4'hF, 32'h0000_0100, 32'h0);
        push_g(1'b1, c);
        push_a(c + 1, 1'b1, 1'b0, 4'hF, 32'h0000_0100, 32'h0, 1'b1, 1'b1);
        tick();
        drop_lsu();
        tick();
        tick();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        rsp_delay = 0;
        push_a(cyc, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b1);
        tick();
        man_rvalid = 1'b1;
        man_rdata  = 32'h1234_5678;
        tick();
        man_rvalid = 1'b0;
        man_rdata  = '0;
        c = cyc;
        drive_if(32'h0000_0010);
        drive_lsu(1'b0, 4'hF, 32'h0000_0100, 32'h0);
        push_g(1'b1, c);
        push_g(1'b0, c + 3);
        push_r(1'b1, 32'h1122_BEEF, c + 2);
        push_r(1'b0, 32'h0050_0093, c + 5);
        tick();
        drop_lsu();
        tick();
        tick();
        tick();
        drop_if();
        wait_idle();

        // Spurious response and grant in IDLE, spurious response in REQ
        c = cyc;
        man_rvalid = 1'b1;
        man_gnt    = 1'b1;
        man_rdata  = 32'hBAD0_BAD0;
        push_a(c + 1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        tick();
        man_rvalid = 1'b0;
        man_gnt    = 1'b0;
        man_rdata  = '0;
        c = cyc;
        stall_cfg = 2;
        drive_if(32'h0000_0010);
        push_g(1'b0, c);
        push_r(1'b0, 32'h0050_0093, c + 4);
        tick();
        drop_if();
        man_rvalid = 1'b1;
        man_rdata  = 32'hBAD0_BAD0;
        push_a(c + 2, 1'b1, 1'b0, 4'hF, 32'h0000_0010, 32'h0, 1'b1, 1'b0);
        tick();
        man_rvalid = 1'b0;
        man_rdata  = '0;
        tick();
        tick();
        stall_cfg = 0;
        wait_idle();

        done = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (mon_done) break;
            tick();
        end
        if (!mon_done) begin
            $display("FAIL monitor_end: got 0 expected 1 (monitor did not finish)");
            $fatal(1, "monitor did not finish");
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter that shares one single-port memory between the pipeline's instruction-fetch (IF) port and load/store unit (LSU) port. It sits between the core's fetch/MEM stages and the unified memory. It keeps one transaction outstanding at a time and uses round-robin priority on simultaneous requests. All memory-side outputs are registered.

## Interface
- XLEN, riscv_pkg::XLEN (32): address/data width
- clk_i  in  1  clock, all logic on rising edge
- rst_i  in  1  synchronous, active-high reset
- if_req_i  in  1  IF request; held with if_addr_i stable until if_gnt_o
- if_addr_i  in  XLEN  IF byte address (always a read)
- if_gnt_o  out  1  IF request accepted (one-cycle pulse)
- if_rvalid_o  out  1  IF response valid (one-cycle pulse)
- if_rdata_o  out  XLEN  IF read data; 0 when if_rvalid_o=0
- lsu_req_i  in  1  LSU request; attributes held stable until lsu_gnt_o
- lsu_we_i  in  1  1=write, 0=read
- lsu_be_i  in  4  byte enables
- lsu_addr_i  in  XLEN  LSU byte address
- lsu_wdata_i  in  XLEN  write data
- lsu_gnt_o  out  1  LSU request accepted (pulse)
- lsu_rvalid_o  out  1  LSU response valid (pulse, also for writes)
- lsu_rdata_o  out  XLEN  LSU read data; 0 when lsu_rvalid_o=0
- mem_req_o  out  1  memory request, held until mem_gnt_i
- mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o  out  1/4/XLEN/XLEN  registered attributes
- mem_gnt_i  in  1  memory accepts request in this cycle
- mem_rvalid_i  in  1  memory response; earliest one cycle after mem_gnt_i
- mem_rdata_i  in  XLEN  memory read data

## Operation
- FSM: IDLE, REQ, RSP.
- IDLE:
  - If any requester is asserting req, choose a winner and pulse that winner's gnt_o combinationally in the same cycle.
  - On that edge, latch owner, we, be, addr and wdata into the mem_* registers, then go to REQ. IF transactions force we=0 and be=4'hF.
- REQ: mem_req_o=1 with the latched attributes. On mem_gnt_i=1, go to RSP. Otherwise stay in REQ with attributes unchanged.
- RSP: wait for mem_rvalid_i. In the cycle it arrives:
  - Pulse the owner's rvalid_o and drive mem_rdata_i on the owner's rdata_o (combinational pass-through).
  - Go to IDLE.
- Arbitration:
  - A single requester always wins.
  - If both request, the requester not served last wins. The last-served pointer updates on every grant.
  - Reset value of the pointer is IF, so the first tie goes to LSU.
- No new grant is issued outside IDLE. Requests asserted during REQ/RSP wait, and the requester keeps req held.
- mem_rvalid_i outside RSP is ignored; no rvalid_o is generated.
- mem_gnt_i outside REQ is ignored.
- Write responses forward mem_rdata_i unchanged. The LSU ignores it.
- Reset (any state, including mid-transaction):
  - FSM returns to IDLE and the pending transaction is dropped; no rvalid_o is issued for it.
  - The memory is reset alongside.

## Timing
- Reset values: mem_req_o=0, mem_we_o=0, mem_be_o=0, mem_addr_o=0, mem_wdata_o=0, last-served=IF. All gnt_o/rvalid_o/rdata_o are 0.
- A request is present in IDLE in cycle N:
  - gnt_o in cycle N.
  - mem_req_o from cycle N+1.
  - With mem_gnt_i in N+1, the earliest mem_rvalid_i, and therefore the requester's rvalid_o, is in N+2.
  - FSM is back in IDLE in N+3.
- Minimum transaction period: 3 cycles. Each mem_gnt_i stall cycle adds 1, and each cycle of response delay adds 1.
- The requester may drop or change req in cycle N+1 after gnt in cycle N. A req still high in N+1 is treated as a new request.
- if_gnt_o and lsu_gnt_o are never high in the same cycle. Neither are if_rvalid_o and lsu_rvalid_o.

## Test plan
- IF read only:
  - Stimulus: if_req_i=1 with addr 0x00000010 in cycle 0; memory grants in cycle 1; mem_rdata_i=0x00500093 in cycle 2.
  - Expected: if_gnt_o in cycle 0; mem_addr_o=0x10 and mem_we_o=0 in cycle 1; if_rvalid_o=1 with if_rdata_o=0x00500093 in cycle 2; lsu_* outputs stay 0.
- LSU write:
  - Stimulus: we=1, be=4'b0011, addr 0x100, wdata 0xDEADBEEF.
  - Expected: mem_* registers carry exactly these values; a single lsu_rvalid_o pulse follows.
- Simultaneous requests after reset, both held:
  - Expected: grants in order LSU, IF, LSU, IF (strict alternation), each 3 cycles apart with zero-wait memory.
- Memory stall:
  - Stimulus: mem_gnt_i held low 4 cycles in REQ.
  - Expected: mem_req_o and attributes stay stable all 4 cycles; no second gnt_o is issued; rvalid_o arrives 4 cycles later than the zero-wait case.
- Reset mid-RSP:
  - Stimulus: rst_i=1 for 1 cycle while waiting for the response; a stray mem_rvalid_i arrives after reset.
  - Expected: no rvalid_o is issued; outputs are at their reset values; the next tie goes to LSU.
- Spurious responses:
  - Stimulus: mem_rvalid_i=1 while in IDLE or REQ.
  - Expected: no rvalid_o pulse; FSM state unchanged.
